debounce_edge_detect: RTL and testbench

// - Multi-channel successor to the single-bit one-cycle edge pulser.
// - Per channel: synchronise an asynchronous raw input, debounce it, then emit a
//   one-clock pulse on the selected edge(s). Also keeps a sticky event flag that

---
 rtl/debounce_edge_detect.sv | 135 +++++++++++++
 tb/tb_debounce_edge_detect.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge_detect.sv
// ---------------------------------------------------------------------------
// debounce_edge_detect
//
// Purpose: per-channel synchroniser + debouncer + edge pulser with a sticky,
// software-clearable event flag. Sits between board-level inputs (buttons,
// switches, strobes) and core/MMIO logic. Every output is registered.
//
// Parameters:
//   CHANNELS        number of independent channels (>=1)
//   SYNC_STAGES     synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES consecutive cycles a changed input must hold (>=1)
//   EDGE_MODE       0=rising, 1=falling, 2/3=both edges
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset, highest priority
//   raw_in     in   asynchronous raw inputs
//   en         in   per-channel enable for pulse / event_flag
//   clr        in   per-channel sticky-flag clear (a same-cycle set wins)
//   level      out  debounced, synchronised level
//   pulse      out  one-cycle pulse on each accepted selected edge,
//                   asserted in the same cycle level shows its new value
//   event_flag out  sticky "selected edge occurred" flag
//   any_event  out  OR of event_flag, lagging it by one cycle
//
// There is no valid/ready handshake: every output is a registered level that
// is meaningful on every cycle.
// ---------------------------------------------------------------------------
module debounce_edge_detect #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_MODE       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] clr,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] pulse,
    output logic [CHANNELS-1:0] event_flag,
    output logic                any_event
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0]                  sync_s;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q;
    logic [CHANNELS-1:0][CW-1:0]          cnt_d;
    logic [CHANNELS-1:0]                  level_q;
    logic [CHANNELS-1:0]                  level_d;
    logic [CHANNELS-1:0]                  rise;
    logic [CHANNELS-1:0]                  fall;
    logic [CHANNELS-1:0]                  sel;
    logic [CHANNELS-1:0]                  pulse_q;
    logic [CHANNELS-1:0]                  pulse_d;
    logic [CHANNELS-1:0]                  flag_q;
    logic [CHANNELS-1:0]                  flag_d;
    logic                                 any_q;

    // Synchroniser chain: stage 0 samples the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive cycles the synchronised input disagrees
    // with the accepted level; accept on the DEBOUNCE_CYCLES-th disagreement.
    // Any agreement restarts the count, so short glitches are discarded.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Edges are decoded from the level transition happening at this edge, so
    // pulse lines up with the cycle in which level first shows the new value.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
        sel = rise | fall;
        case (EDGE_MODE)
            0:       sel = rise;
            1:       sel = fall;
            default: sel = rise | fall;
        endcase
    end

    assign pulse_d = sel & en;
    // Set dominates clear when both happen in the same cycle.
    assign flag_d  = (flag_q & ~clr) | pulse_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            any_q   <= |flag_q;
        end
    end

    assign level      = level_q;
    assign pulse      = pulse_q;
    assign event_flag = flag_q;
    assign any_event  = any_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// ---------------------------------------------------------------------------
// tb_debounce_edge_detect
//
// Four instances (EDGE_MODE 0..3) share random raw_in/en/clr/rst stimulus.
// A reference model written from the behavioural rules (delay line, "last
// DEBOUNCE_CYCLES samples all disagree with level" acceptance, edge select,
// sticky flag, lagging OR) pushes one expected output word per clock into
// exp_q; a monitor pops and compares after every posedge.
// ---------------------------------------------------------------------------
module tb_debounce_edge_detect;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 16;
    localparam int NDUT = 4;
    localparam int VW   = 13;
    localparam int NCYC = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] raw_in;
    logic [CH-1:0] en;
    logic [CH-1:0] clr;
    logic [CH-1:0] lvl [NDUT];
    logic [CH-1:0] pls [NDUT];
    logic [CH-1:0] evf [NDUT];
    logic          anyv[NDUT];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NDUT; g++) begin : g_dut
            debounce_edge_detect #(
                .CHANNELS(CH),
                .SYNC_STAGES(SYNC),
                .DEBOUNCE_CYCLES(DEB),
                .EDGE_MODE(g)
            ) u_dut (
                .clk(clk),
                .rst(rst),
                .raw_in(raw_in),
                .en(en),
                .clr(clr),
                .level(lvl[g]),
                .pulse(pls[g]),
                .event_flag(evf[g]),
                .any_event(anyv[g])
            );
        end
    endgenerate

    // Scoreboard
    logic [NDUT*VW-1:0] exp_q[$];
    int checks = 0;
    int passed = 0;

    // Reference model state
    bit pipe_q [CH][$];
    bit shist  [CH][$];
    bit m_level[CH];
    bit m_pulse[NDUT][CH];
    bit m_flag [NDUT][CH];
    bit m_any  [NDUT];
    int hold   [CH];

    task automatic model_step(input logic [CH-1:0] r, input logic [CH-1:0] e,
                              input logic [CH-1:0] c, input logic rs);
        logic [NDUT*VW-1:0] v;
        bit s_old, nl, all_diff, rise, fall, sel, any_old;
        v = '0;
        if (rs) begin
            for (int ch = 0; ch < CH; ch++) begin
                pipe_q[ch].delete();
                for (int k = 0; k < SYNC; k++) pipe_q[ch].push_back(1'b0);
                shist[ch].delete();
                m_level[ch] = 1'b0;
                for (int m = 0; m < NDUT; m++) begin
                    m_pulse[m][ch] = 1'b0;
                    m_flag[m][ch]  = 1'b0;
                end
            end
            for (int m = 0; m < NDUT; m++) m_any[m] = 1'b0;
        end else begin
            // any_event reflects the flags as they stood before this edge
            for (int m = 0; m < NDUT; m++) begin
                any_old = 1'b0;
                for (int ch = 0; ch < CH; ch++) any_old = any_old | m_flag[m][ch];
                m_any[m] = any_old;
            end
            for (int ch = 0; ch < CH; ch++) begin
                s_old = pipe_q[ch].pop_front();
                pipe_q[ch].push_back(r[ch]);
                shist[ch].push_back(s_old);
                if (shist[ch].size() > DEB) void'(shist[ch].pop_front());
                nl = m_level[ch];
                if (shist[ch].size() == DEB) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < shist[ch].size(); j++)
                        if (shist[ch][j] == m_level[ch]) all_diff = 1'b0;
                    if (all_diff) nl = s_old;
                end
                rise = nl & !m_level[ch];
                fall = !nl & m_level[ch];
                m_level[ch] = nl;
                for (int m = 0; m < NDUT; m++) begin
                    sel = (m == 0) ? rise : (m == 1) ? fall : (rise | fall);
                    m_pulse[m][ch] = sel & e[ch];
                    m_flag[m][ch]  = (m_flag[m][ch] & !c[ch]) | m_pulse[m][ch];
                end
            end
        end
        for (int m = 0; m < NDUT; m++) begin
            for (int ch = 0; ch < CH; ch++) begin
                v[m*VW + ch]     = m_level[ch];
                v[m*VW + 4 + ch] = m_pulse[m][ch];
                v[m*VW + 8 + ch] = m_flag[m][ch];
            end
            v[m*VW + 12] = m_any[m];
        end
        exp_q.push_back(v);
    endtask

    // Driver: new inputs on every negedge, expected response pushed alongside
    initial begin
        rst    = 1'b1;
        raw_in = '0;
        en     = '1;
        clr    = '0;
        for (int ch = 0; ch < CH; ch++) hold[ch] = $urandom_range(20, 60);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = (cyc < 3) || (cyc == 1410) || ($urandom_range(0, 599) == 0);
            for (int ch = 0; ch < CH; ch++) begin
                if (hold[ch] == 0) begin
                    raw_in[ch] = ~raw_in[ch];
                    // mix long holds with glitches around the debounce boundary
                    hold[ch] = ($urandom_range(0, 9) < 7) ? $urandom_range(20, 60)
                                                          : $urandom_range(1, 18);
                end else begin
                    hold[ch] = hold[ch] - 1;
                end
            end
            // all inputs held high with a reset landing mid-debounce
            if (cyc >= 1400 && cyc < 1460) begin
                raw_in = '1;
                en     = '1;
            end else if ($urandom_range(0, 49) == 0) begin
                en = CH'($urandom);
            end
            for (int ch = 0; ch < CH; ch++) clr[ch] = ($urandom_range(0, 15) == 0);
            model_step(raw_in, en, clr, rst);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain leftover=%0d required=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Monitor: compare every instance's outputs shortly after each posedge
    logic [NDUT*VW-1:0] exp_v;
    logic [VW-1:0]      act_v;
    int                 out_idx = 0;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            for (int d = 0; d < NDUT; d++) begin
                act_v = {anyv[d], evf[d], pls[d], lvl[d]};
                checks++;
                if (act_v === exp_v[d*VW +: VW]) passed++;
                else $display("FAIL mode%0d_outputs cycle=%0d actual=%h required=%h (any,flag,pulse,level)",
                              d, out_idx, act_v, exp_v[d*VW +: VW]);
            end
            out_idx++;
        end
    end

endmodule
